// File: rtl/dft_pkg.sv
// Shared types and helpers for the direct-DFT sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dft_pkg;

    // Default index/address width of the DFT datapath
    localparam int DFT_ADDR_W = 12;

    // Sequencer states; encoding is visible on the state output
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        COMPUTE = 3'd2,
        DRAIN   = 3'd3,
        DONE    = 3'd4
    } dft_state_t;

    // (a + b) mod m for a < m and b < m; one extra bit of headroom makes a
    // single conditional subtract sufficient. Operands are carried at 32 bits
    // so any index width up to 31 bits can use it.
    function automatic logic [31:0] mod_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] m);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= {1'b0, m}) begin
            sum = sum - {1'b0, m};
        end
        return sum[31:0];
    endfunction

endpackage

// File: rtl/dft_valid_delay.sv
// Shift register carrying {last flag, bin index} from issue to MAC result.
// Latency: DEPTH ce-cycles from din to dout.
// Backpressure: none; ce freezes every stage, flush zeroes them (flush wins).
module dft_valid_delay #(
    parameter int W     = 13,
    parameter int DEPTH = 3
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         ce,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] pipe [DEPTH];

    // Advance one stage per enabled cycle; flush discards everything in flight
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe[i] <= '0;
            end
        end else if (ce) begin
            pipe[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/dft_sequencer.sv
// Direct-DFT sequencer: loads N samples, issues all (n,k) pairs with twiddle
// addresses, strobes per-bin results and signals done. Issue 1 cycle after
// state entry, results PIPE_LAT ce-cycles after issue. ce=0 freezes all.
// Optional: DFT_HALF_SPECTRUM_EN restricts k to 0..floor(N/2).
module dft_sequencer
    import dft_pkg::*;
#(
    parameter int ADDR_W   = DFT_ADDR_W,
    parameter int PIPE_LAT = 3
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              ce,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] sample_num,
    input  logic              load_valid,
    output logic              load_we,
    output logic [ADDR_W-1:0] load_addr,
    output logic [ADDR_W-1:0] n_idx,
    output logic [ADDR_W-1:0] k_idx,
    output logic [ADDR_W-1:0] tw_addr,
    output logic              acc_clear,
    output logic              acc_en,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_k,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic [2:0]        state
);

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] TWO = ADDR_W'(2);
    localparam int DRAIN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(PIPE_LAT - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_ONE  = DRAIN_W'(1);

    dft_state_t         state_r;
    logic [ADDR_W-1:0]  n_lat;
    logic [ADDR_W-1:0]  cnt;
    logic [ADDR_W-1:0]  n_last;
    logic [ADDR_W-1:0]  k_last;
    logic [ADDR_W-1:0]  tw_next;
    logic [DRAIN_W-1:0] drain_cnt;
    logic               dly_ce;
    logic               dly_flush;
    logic [ADDR_W:0]    dly_in;
    logic [ADDR_W:0]    dly_out;

    assign n_last = n_lat - ONE;

`ifdef DFT_HALF_SPECTRUM_EN
    // Real input: bins above N/2 are conjugates and are skipped
    assign k_last = n_lat >> 1;
`else
    assign k_last = n_last;
`endif

    // Next twiddle address for the following n of the same bin
    assign tw_next = ADDR_W'(mod_add(32'(tw_addr), 32'(k_idx), 32'(n_lat)));

    assign load_we   = load_valid & ce & (state_r == LOAD);
    assign load_addr = cnt;
    assign busy      = (state_r != IDLE);
    assign state     = state_r;

    // Sequencer FSM; the issue registers double as the n/k/tw counters
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r   <= IDLE;
            n_lat     <= '0;
            cnt       <= '0;
            n_idx     <= '0;
            k_idx     <= '0;
            tw_addr   <= '0;
            acc_clear <= 1'b0;
            acc_en    <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
            drain_cnt <= '0;
        end else if (ce) begin
            if (abort) begin
                state_r   <= IDLE;
                cnt       <= '0;
                acc_clear <= 1'b0;
                acc_en    <= 1'b0;
                done      <= 1'b0;
                drain_cnt <= '0;
            end else begin
                case (state_r)
                    IDLE: begin
                        done <= 1'b0;
                        if (start) begin
                            if (sample_num < TWO) begin
                                cfg_err <= 1'b1;
                            end else begin
                                n_lat   <= sample_num;
                                cnt     <= '0;
                                n_idx   <= '0;
                                k_idx   <= '0;
                                tw_addr <= '0;
                                cfg_err <= 1'b0;
                                state_r <= LOAD;
                            end
                        end
                    end
                    LOAD: begin
                        if (load_valid) begin
                            if (cnt == n_last) begin
                                cnt       <= '0;
                                n_idx     <= '0;
                                k_idx     <= '0;
                                tw_addr   <= '0;
                                acc_clear <= 1'b1;
                                acc_en    <= 1'b1;
                                state_r   <= COMPUTE;
                            end else begin
                                cnt <= cnt + ONE;
                            end
                        end
                    end
                    COMPUTE: begin
                        if (n_idx == n_last) begin
                            if (k_idx == k_last) begin
                                acc_clear <= 1'b0;
                                acc_en    <= 1'b0;
                                drain_cnt <= '0;
                                state_r   <= DRAIN;
                            end else begin
                                n_idx     <= '0;
                                tw_addr   <= '0;
                                k_idx     <= k_idx + ONE;
                                acc_clear <= 1'b1;
                            end
                        end else begin
                            n_idx     <= n_idx + ONE;
                            tw_addr   <= tw_next;
                            acc_clear <= 1'b0;
                        end
                    end
                    DRAIN: begin
                        if (drain_cnt == DRAIN_LAST) begin
                            done    <= 1'b1;
                            state_r <= DONE;
                        end else begin
                            drain_cnt <= drain_cnt + DRAIN_ONE;
                        end
                    end
                    DONE: begin
                        done    <= 1'b0;
                        state_r <= IDLE;
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

    // Tag the final n of each bin so the bin index emerges with its result
    assign dly_in    = {acc_en & (n_idx == n_last), k_idx};
    assign dly_ce    = ce & ((state_r == COMPUTE) | (state_r == DRAIN));
    assign dly_flush = ce & abort;

    dft_valid_delay #(
        .W     (ADDR_W + 1),
        .DEPTH (PIPE_LAT)
    ) u_valid_delay (
        .clk   (clk),
        .nrst  (nrst),
        .ce    (dly_ce),
        .flush (dly_flush),
        .din   (dly_in),
        .dout  (dly_out)
    );

    assign out_valid = dly_out[ADDR_W];
    assign out_k     = dly_out[ADDR_W-1:0];

endmodule

// File: tb/tb_dft_sequencer.sv
// Self-checking bench for dft_sequencer: randomized ce/load/start stimulus,
// expected issue/bin/done streams computed from plain DFT index arithmetic.
// Honours DFT_HALF_SPECTRUM_EN for the bin range.
module tb_dft_sequencer;

    localparam int AW = 12;
    localparam int PL = 3;
`ifdef DFT_HALF_SPECTRUM_EN
    localparam bit HALF = 1'b1;
`else
    localparam bit HALF = 1'b0;
`endif

    logic          clk;
    logic          nrst;
    logic          ce;
    logic          start;
    logic          abort;
    logic [AW-1:0] sample_num;
    logic          load_valid;
    logic          load_we;
    logic [AW-1:0] load_addr;
    logic [AW-1:0] n_idx;
    logic [AW-1:0] k_idx;
    logic [AW-1:0] tw_addr;
    logic          acc_clear;
    logic          acc_en;
    logic          out_valid;
    logic [AW-1:0] out_k;
    logic          busy;
    logic          done;
    logic          cfg_err;
    logic [2:0]    state;

    int n_cmp = 0;
    int n_bad = 0;

    // Observed event streams, tagged with the ce-cycle index they occurred in
    int          ce_idx = 0;
    logic [63:0] iss_q[$];
    logic [63:0] bin_q[$];
    int          done_q[$];
    int          load_q[$];
    int          load_ce_q[$];

    logic [63:0] snap;
    logic        prev_ce   = 1'b0;
    logic        prev_nrst = 1'b0;

    dft_sequencer #(.ADDR_W(AW), .PIPE_LAT(PL)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .ce         (ce),
        .start      (start),
        .abort      (abort),
        .sample_num (sample_num),
        .load_valid (load_valid),
        .load_we    (load_we),
        .load_addr  (load_addr),
        .n_idx      (n_idx),
        .k_idx      (k_idx),
        .tw_addr    (tw_addr),
        .acc_clear  (acc_clear),
        .acc_en     (acc_en),
        .out_valid  (out_valid),
        .out_k      (out_k),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] out_snap();
        return {7'd0, state, n_idx, k_idx, tw_addr, acc_en, acc_clear,
                out_valid, out_k, done, busy, cfg_err};
    endfunction

    // Monitor: record events on enabled cycles, and verify nothing moved
    // across a cycle where ce was low
    always @(negedge clk) begin
        if (nrst) begin
            if (prev_nrst && !prev_ce) begin
                check("hold_ce0", out_snap(), snap);
            end
            if (ce) begin
                if (load_we) begin
                    load_q.push_back(int'(load_addr));
                    load_ce_q.push_back(ce_idx);
                end
                if (acc_en) begin
                    iss_q.push_back({11'd0, ce_idx[15:0], n_idx, k_idx, tw_addr, acc_clear});
                end
                if (out_valid) begin
                    bin_q.push_back(64'({ce_idx[15:0], out_k}));
                end
                if (done) begin
                    done_q.push_back(ce_idx);
                end
                ce_idx++;
            end
        end
        snap      = out_snap();
        prev_ce   = ce;
        prev_nrst = nrst;
    end

    // One transform of N samples; ce_mode 0=always on, 1=toggle, 2=random.
    // abort_at>0 aborts while that (1-based) issue is on the outputs.
    task automatic run(input int nval, input int ce_mode, input int abort_at);
        int kmax;
        int total;
        int n_exp;
        int anchor;
        int cyc;
        int lim;
        int li;
        bit hit;
        logic [63:0] exp_bin[$];

        kmax  = HALF ? (nval / 2) : (nval - 1);
        total = nval * (kmax + 1);
        n_exp = (abort_at > 0) ? abort_at : total;
        iss_q.delete();
        bin_q.delete();
        done_q.delete();
        load_q.delete();
        load_ce_q.delete();

        @(posedge clk); #1;
        start = 1'b1; sample_num = AW'(nval); ce = 1'b1; abort = 1'b0; load_valid = 1'b0;
        @(posedge clk); #1;
        check("start_state", 64'(state), 64'(1));
        check("start_cfg_err", 64'(cfg_err), 64'(0));
        start = 1'b0;

        cyc = 0;
        while (1) begin
            if (done_q.size() > 0) break;
            if (cyc > 5000) begin
                check("timeout", 64'(cyc), 64'(0));
                break;
            end
            hit = (abort_at > 0) && acc_en && (iss_q.size() == abort_at - 1);
            if (hit) begin
                abort = 1'b1; ce = 1'b1; start = 1'b0;
            end else begin
                case (ce_mode)
                    0:       ce = 1'b1;
                    1:       ce = ~ce;
                    default: ce = ($urandom_range(0, 3) != 0);
                endcase
                load_valid = ($urandom_range(0, 3) != 0);
                start      = $urandom_range(0, 1) == 1;
                sample_num = AW'($urandom);
            end
            @(posedge clk); #1;
            cyc++;
            if (hit) begin
                abort = 1'b0;
                check("abort_idle", 64'(state), 64'(0));
                break;
            end
        end
        start = 1'b0; ce = 1'b1; load_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;

        // Sample RAM writes: addresses 0..N-1 in order
        check("load_cnt", 64'(load_q.size()), 64'(nval));
        for (int i = 0; i < load_q.size() && i < nval; i++) begin
            check("load_addr", 64'(load_q[i]), 64'(i));
        end
        anchor = (load_ce_q.size() > 0) ? load_ce_q[load_ce_q.size() - 1] + 1 : 0;

        // Issues: k-major, n-minor, back to back in ce-cycles, tw = n*k mod N
        check("iss_cnt", 64'(iss_q.size()), 64'(n_exp));
        lim = (iss_q.size() < n_exp) ? iss_q.size() : n_exp;
        for (int i = 0; i < lim; i++) begin
            int n;
            int k;
            int c;
            n = i % nval;
            k = i / nval;
            c = anchor + i;
            check("issue", iss_q[i],
                  {11'd0, c[15:0], AW'(n), AW'(k), AW'((n * k) % nval), (n == 0)});
        end

        // Bin results PIPE_LAT ce-cycles after the final n of each bin
        for (int k = 0; k <= kmax; k++) begin
            int c;
            li = k * nval + nval - 1;
            c  = anchor + li + PL;
            if (li < n_exp && (abort_at == 0 || li + PL <= abort_at - 1)) begin
                exp_bin.push_back(64'({c[15:0], AW'(k)}));
            end
        end
        check("bin_cnt", 64'(bin_q.size()), 64'(exp_bin.size()));
        for (int i = 0; i < bin_q.size() && i < exp_bin.size(); i++) begin
            check("bin", bin_q[i], exp_bin[i]);
        end

        check("done_cnt", 64'(done_q.size()), 64'((abort_at > 0) ? 0 : 1));
        if (abort_at == 0 && done_q.size() > 0) begin
            check("done_ce", 64'(done_q[0]), 64'(anchor + total + PL));
        end
        check("end_state", 64'(state), 64'(0));
        check("end_busy", 64'(busy), 64'(0));
    endtask

    initial begin
        nrst = 1'b1; ce = 1'b0; start = 1'b0; abort = 1'b0;
        sample_num = '0; load_valid = 1'b0;
        #2 nrst = 1'b0;
        #2;
        check("rst_idx", 64'({n_idx, k_idx, tw_addr, load_addr, out_k}), 64'(0));
        check("rst_ctl", 64'({load_we, acc_clear, acc_en, out_valid, busy, done, cfg_err}), 64'(0));
        check("rst_state", 64'(state), 64'(0));
        repeat (2) @(posedge clk);
        #1 nrst = 1'b1;

        run(4, 0, 0);
        run(5, 1, 0);

        // Bad configuration is flagged and does not leave IDLE
        @(posedge clk); #1;
        start = 1'b1; sample_num = AW'(1); ce = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("cfg_err_n1", 64'(cfg_err), 64'(1));
        check("cfg_state_n1", 64'(state), 64'(0));
        start = 1'b1; sample_num = AW'(0);
        @(posedge clk); #1;
        start = 1'b0;
        check("cfg_err_n0", 64'(cfg_err), 64'(1));
        check("cfg_busy_n0", 64'(busy), 64'(0));
        run(3, 0, 0);

        run(4, 0, 7);

        // Asynchronous reset in the middle of LOAD
        @(posedge clk); #1;
        start = 1'b1; sample_num = AW'(4); ce = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; load_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("mid_load_state", 64'(state), 64'(1));
        nrst = 1'b0;
        #1;
        check("mrst_idx", 64'({n_idx, k_idx, tw_addr, load_addr, out_k}), 64'(0));
        check("mrst_ctl", 64'({load_we, acc_clear, acc_en, out_valid, busy, done, cfg_err}), 64'(0));
        check("mrst_state", 64'(state), 64'(0));
        load_valid = 1'b0;
        @(posedge clk); #1;
        nrst = 1'b1;
        run(2, 0, 0);

        run(6, 2, 0);
        for (int r = 0; r < 4; r++) begin
            run($urandom_range(2, 9), 2, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
